// File: rtl/ksa_addsub_pipe.sv
// Pipelined 32-bit Kogge-Stone adder/subtractor with valid/ready on both sides.
// Prefix levels 1 / 2-3 / 4-5 are split over three register stages; stage 3 is the output register.
module ksa_addsub_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_s,
   output logic             out_cb,
   output logic             out_ovf,
   output logic             out_zero
);

   generate
      if (WIDTH != 32 || STAGES != 3) begin : g_bad_param
         $error("ksa_addsub_pipe supports only WIDTH=32 and STAGES=3");
      end
   endgenerate

   // One Kogge-Stone level: bit i combines with bit i-span, lower bits pass through.
   function automatic logic [2*WIDTH-1:0] prefix(input logic [WIDTH-1:0] g,
                                                 input logic [WIDTH-1:0] p,
                                                 input int span);
      logic [WIDTH-1:0] go;
      logic [WIDTH-1:0] po;
      go = g;
      po = p;
      for (int i = 0; i < WIDTH; i++) begin
         if (i >= span) begin
            go[i] = g[i] | (p[i] & g[i-span]);
            po[i] = p[i] & p[i-span];
         end
      end
      return {go, po};
   endfunction

   logic v1, v2, v3;
   logic ready1, ready2, ready3;

   assign ready3    = !v3 || out_ready;
   assign ready2    = !v2 || ready3;
   assign ready1    = !v1 || ready2;
   assign in_ready  = ready1;
   assign out_valid = v3;

   logic [WIDTH-1:0]   y_eff, g0, p0;
   logic [2*WIDTH-1:0] gp1;

   assign y_eff = in_sub ? ~in_y : in_y;
   assign g0    = in_x & y_eff;
   assign p0    = in_x ^ y_eff;
   assign gp1   = prefix(g0, p0, 1);

   logic [WIDTH-1:0] s1_p0, s1_g, s1_p;
   logic             s1_cin, s1_xs, s1_ys;

   // Stage 1: per-bit propagate, level-1 group terms, carry-in and operand sign bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1     <= 1'b0;
         s1_p0  <= '0;
         s1_g   <= '0;
         s1_p   <= '0;
         s1_cin <= 1'b0;
         s1_xs  <= 1'b0;
         s1_ys  <= 1'b0;
      end else if (ready1) begin
         v1 <= in_valid;
         if (in_valid) begin
            s1_p0  <= p0;
            s1_g   <= gp1[2*WIDTH-1:WIDTH];
            s1_p   <= gp1[WIDTH-1:0];
            s1_cin <= in_sub;
            s1_xs  <= in_x[WIDTH-1];
            s1_ys  <= y_eff[WIDTH-1];
         end
      end
   end

   logic [2*WIDTH-1:0] gp2, gp3;

   assign gp2 = prefix(s1_g, s1_p, 2);
   assign gp3 = prefix(gp2[2*WIDTH-1:WIDTH], gp2[WIDTH-1:0], 4);

   logic [WIDTH-1:0] s2_p0, s2_g, s2_p;
   logic             s2_cin, s2_xs, s2_ys;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2     <= 1'b0;
         s2_p0  <= '0;
         s2_g   <= '0;
         s2_p   <= '0;
         s2_cin <= 1'b0;
         s2_xs  <= 1'b0;
         s2_ys  <= 1'b0;
      end else if (ready2) begin
         v2 <= v1;
         if (v1) begin
            s2_p0  <= s1_p0;
            s2_g   <= gp3[2*WIDTH-1:WIDTH];
            s2_p   <= gp3[WIDTH-1:0];
            s2_cin <= s1_cin;
            s2_xs  <= s1_xs;
            s2_ys  <= s1_ys;
         end
      end
   end

   logic [2*WIDTH-1:0] gp4, gp5;
   logic [WIDTH-1:0]   g5, p5, carry, sum;
   logic               cout;

   assign gp4   = prefix(s2_g, s2_p, 8);
   assign gp5   = prefix(gp4[2*WIDTH-1:WIDTH], gp4[WIDTH-1:0], 16);
   assign g5    = gp5[2*WIDTH-1:WIDTH];
   assign p5    = gp5[WIDTH-1:0];
   assign carry = {g5[WIDTH-2:0] | (p5[WIDTH-2:0] & {(WIDTH-1){s2_cin}}), s2_cin};
   assign sum   = s2_p0 ^ carry;
   assign cout  = g5[WIDTH-1] | (p5[WIDTH-1] & s2_cin);

   // Overflow from the sign bits: same-sign operands giving a different-sign result,
   // equivalent to c[31] ^ cout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3       <= 1'b0;
         out_s    <= '0;
         out_cb   <= 1'b0;
         out_ovf  <= 1'b0;
         out_zero <= 1'b0;
      end else if (ready3) begin
         v3 <= v2;
         if (v2) begin
            out_s    <= sum;
            out_cb   <= s2_cin ? ~cout : cout;
            out_ovf  <= (s2_xs == s2_ys) && (sum[WIDTH-1] != s2_xs);
            out_zero <= ~|sum;
         end
      end
   end

endmodule

// File: tb/tb_ksa_addsub_pipe.sv
// Self-checking bench for ksa_addsub_pipe: directed test-plan vectors, backpressure,
// mid-flight reset and a random handshake regression against an arithmetic model.
module tb_ksa_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_x = '0;
   logic [31:0] in_y = '0;
   logic        in_sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_s;
   logic        out_cb, out_ovf, out_zero;

   int checks = 0;
   int errors = 0;

   logic [34:0] expq[$];
   logic [34:0] hold;
   bit          have_hold = 0;
   logic [35:0] dut_now;

   ksa_addsub_pipe #(.WIDTH(32), .STAGES(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_s(out_s), .out_cb(out_cb), .out_ovf(out_ovf), .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   assign dut_now = {out_valid, out_s, out_cb, out_ovf, out_zero};

   // Reference result {s, cb, ovf, zero} from plain unsigned/signed arithmetic.
   function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic sub);
      longint sx, sy, r;
      logic [31:0] s;
      logic        cb, ovf;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (sub) begin
         s  = x - y;
         cb = (x < y);
         r  = sx - sy;
      end else begin
         s  = x + y;
         cb = (({1'b0, x} + {1'b0, y}) > 33'h0FFFFFFFF);
         r  = sx + sy;
      end
      ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      return {s, cb, ovf, (s == 32'd0)};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom % 16)
         0: return 32'h00000000;
         1: return 32'hFFFFFFFF;
         2: return 32'h7FFFFFFF;
         3: return 32'h80000000;
         4: return 32'h00000001;
         default: return $urandom;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [35:0] got, input logic [35:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   // Acceptance is decided at the negedge; inputs only change #1 after posedge.
   task automatic cycle(output bit acc);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
   endtask

   // Single op into an idle pipe; result must show after the third edge counting the accept edge.
   task automatic applyStimulus(input string name, input logic [31:0] x, input logic [31:0] y,
                                input logic sub, input logic [31:0] es, input logic ecb,
                                input logic eovf, input logic ezero);
      bit acc;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_x      = x;
      in_y      = y;
      in_sub    = sub;
      cycle(acc);
      in_valid = 1'b0;
      in_x     = $urandom;
      in_y     = $urandom;
      checkOutput({name, " accept"}, {35'd0, acc}, 36'd1);
      cycle(acc);
      checkOutput({name, " early"}, {35'd0, out_valid}, 36'd0);
      cycle(acc);
      checkOutput(name, dut_now, {1'b1, es, ecb, eovf, ezero});
   endtask

   // Scoreboard: pop/compare before push so a spurious result never matches a fresh entry.
   always @(negedge clk) begin
      if (!rst_n) begin
         expq.delete();
         have_hold = 0;
      end else begin
         if (have_hold)
            checkOutput("hold stable", dut_now, {1'b1, hold});
         if (out_valid) begin
            if (expq.size() == 0) begin
               checkOutput("spurious result", {35'd0, out_valid}, 36'd0);
            end else if (out_ready) begin
               checkOutput("result", {1'b0, out_s, out_cb, out_ovf, out_zero},
                           {1'b0, expq.pop_front()});
            end
            have_hold = !out_ready;
            hold      = {out_s, out_cb, out_ovf, out_zero};
         end else begin
            have_hold = 0;
         end
         if (in_valid && in_ready)
            expq.push_back(model(in_x, in_y, in_sub));
      end
   end

   initial begin
      bit          acc;
      int          idx;
      logic [31:0] bx[5];
      logic [31:0] by[5];
      logic        bs[5];

      #1 rst_n = 1'b0;
      #2;
      checkOutput("reset outputs", {in_ready, out_valid, out_s, out_cb, out_ovf, out_zero},
                  {1'b1, 1'b0, 32'd0, 3'b000});
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("after release", {in_ready, out_valid, out_s, out_cb, out_ovf, out_zero},
                  {1'b1, 1'b0, 32'd0, 3'b000});

      applyStimulus("add wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
      applyStimulus("sub borrow", 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
      applyStimulus("sub plain", 32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0);
      applyStimulus("add ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      applyStimulus("sub ovf", 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
      cycle(acc);

      // Backpressure: five back-to-back offers against a stalled consumer.
      for (int i = 0; i < 5; i++) begin
         bx[i] = pick();
         by[i] = pick();
         bs[i] = 1'($urandom % 2);
      end
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         in_valid = (idx < 5);
         if (idx < 5) begin
            in_x = bx[idx]; in_y = by[idx]; in_sub = bs[idx];
         end
         cycle(acc);
         if (acc) idx++;
      end
      checkOutput("bp accepted", 36'(idx), 36'd3);
      checkOutput("bp in_ready", {35'd0, in_ready}, 36'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_valid = (idx < 5);
         if (idx < 5) begin
            in_x = bx[idx]; in_y = by[idx]; in_sub = bs[idx];
         end
         @(negedge clk);
         checkOutput($sformatf("bp stream %0d", k), {35'd0, out_valid}, 36'd1);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) idx++;
      end
      in_valid = 1'b0;
      checkOutput("bp all accepted", 36'(idx), 36'd5);
      repeat (2) cycle(acc);

      // Reset with A in the output stage and B in stage 1.
      out_ready = 1'b0;
      in_valid = 1'b1; in_x = 32'h00001234; in_y = 32'h00000011; in_sub = 1'b0;
      cycle(acc);
      in_valid = 1'b0;
      cycle(acc);
      in_valid = 1'b1; in_x = 32'h0000FFFF; in_y = 32'h00000001; in_sub = 1'b1;
      cycle(acc);
      in_valid = 1'b0;
      checkOutput("pre-reset", dut_now, {1'b1, 32'h00001245, 3'b000});
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid reset", {in_ready, dut_now}, {1'b1, 1'b0, 32'd0, 3'b000});
      @(posedge clk);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle(acc);
         checkOutput($sformatf("no stale %0d", k), {35'd0, out_valid}, 36'd0);
      end
      applyStimulus("post reset", 32'h00000010, 32'h00000020, 1'b1, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0);

      // Random regression with random valid/ready toggling.
      for (int c = 0; c < 20000; c++) begin
         in_valid  = (($urandom % 4) != 0);
         out_ready = (($urandom % 4) != 0);
         in_x      = pick();
         in_y      = pick();
         in_sub    = 1'($urandom % 2);
         cycle(acc);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && expq.size() != 0; c++)
         cycle(acc);
      checkOutput("drain", 36'(expq.size()), 36'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
